mem_arbiter: RTL and testbench

//  Shares one byte-wide synchronous RAM port between the IF stage (instruction fetch) and the MEM stage (loads/stores).

---
 rtl/mem_arbiter.sv | 225 ++++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Arbitrates a single byte-wide synchronous RAM port between instruction fetch and load/store.
// Each access is serialised into little-endian byte transfers; read data is reassembled and extended.
module mem_arbiter #(
  parameter int MEM_ADDR_W = 17
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req,
  input  logic [31:0]           if_addr,
  input  logic                  if_cancel,
  output logic                  if_done,
  output logic [31:0]           if_inst,
  input  logic                  mem_req,
  input  logic                  mem_we,
  input  logic [1:0]            mem_size,
  input  logic                  mem_signed,
  input  logic [31:0]           mem_addr,
  input  logic [31:0]           mem_wdata,
  output logic                  mem_done,
  output logic [31:0]           mem_rdata,
  output logic [MEM_ADDR_W-1:0] ram_a,
  output logic [7:0]            ram_dout,
  output logic                  ram_wr,
  input  logic [7:0]            ram_din,
  output logic                  stall_if,
  output logic                  stall_mem
);

  typedef enum logic [2:0] {IDLE, IF_RD, MEM_RD, MEM_WR, DONE} state_t;

  state_t                state_q, state_d;
  logic [2:0]            cnt_q, cnt_d;
  logic [2:0]            len_q, len_d;
  logic [MEM_ADDR_W-1:0] base_q, base_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [31:0]           buf_q, buf_d;
  logic                  sgn_q, sgn_d;
  logic [MEM_ADDR_W-1:0] ram_a_q, ram_a_d;
  logic [7:0]            ram_dout_q, ram_dout_d;
  logic                  ram_wr_q, ram_wr_d;
  logic                  if_done_q, if_done_d;
  logic                  mem_done_q, mem_done_d;
  logic [31:0]           if_inst_q, if_inst_d;
  logic [31:0]           mem_rdata_q, mem_rdata_d;

  logic [MEM_ADDR_W-1:0] byte_addr;
  logic [2:0]            rd_idx;
  logic [7:0]            wr_byte;
  logic [2:0]            mem_len;
  logic                  unused_addr_bits;

  assign unused_addr_bits = ^{if_addr[31:MEM_ADDR_W], mem_addr[31:MEM_ADDR_W]};

  // cnt_q holds the index of the upcoming edge relative to acceptance (E0).
  assign byte_addr = base_q + MEM_ADDR_W'(cnt_q);
  assign rd_idx    = cnt_q - 3'd2;

  always_comb begin
    wr_byte = wdata_q[7:0];
    case (cnt_q[1:0])
      2'd1:    wr_byte = wdata_q[15:8];
      2'd2:    wr_byte = wdata_q[23:16];
      2'd3:    wr_byte = wdata_q[31:24];
      default: wr_byte = wdata_q[7:0];
    endcase
  end

  always_comb begin
    case (mem_size)
      2'd0:    mem_len = 3'd1;
      2'd1:    mem_len = 3'd2;
      default: mem_len = 3'd4;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    len_d       = len_q;
    base_d      = base_q;
    wdata_d     = wdata_q;
    buf_d       = buf_q;
    sgn_d       = sgn_q;
    ram_a_d     = ram_a_q;
    ram_dout_d  = ram_dout_q;
    ram_wr_d    = ram_wr_q;
    if_done_d   = 1'b0;
    mem_done_d  = 1'b0;
    if_inst_d   = if_inst_q;
    mem_rdata_d = mem_rdata_q;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (mem_req) begin
          base_d  = mem_addr[MEM_ADDR_W-1:0];
          len_d   = mem_len;
          sgn_d   = mem_signed;
          wdata_d = mem_wdata;
          buf_d   = '0;
          cnt_d   = 3'd1;
          ram_a_d = mem_addr[MEM_ADDR_W-1:0];
          if (mem_we) begin
            state_d    = MEM_WR;
            ram_wr_d   = 1'b1;
            ram_dout_d = mem_wdata[7:0];
          end else begin
            state_d = MEM_RD;
          end
        end else if (if_req) begin
          base_d  = if_addr[MEM_ADDR_W-1:0];
          len_d   = 3'd4;
          sgn_d   = 1'b0;
          buf_d   = '0;
          cnt_d   = 3'd1;
          ram_a_d = if_addr[MEM_ADDR_W-1:0];
          state_d = IF_RD;
        end
      end

      IF_RD, MEM_RD: begin
        if (state_q == IF_RD && if_cancel) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 3'd1;
          if (cnt_q < len_q) ram_a_d = byte_addr;
          // RAM returns the byte for address k two edges after it was issued.
          if (cnt_q >= 3'd2) begin
            case (rd_idx[1:0])
              2'd0:    buf_d[7:0]   = ram_din;
              2'd1:    buf_d[15:8]  = ram_din;
              2'd2:    buf_d[23:16] = ram_din;
              default: buf_d[31:24] = ram_din;
            endcase
          end
          if (cnt_q == len_q + 3'd1) begin
            state_d = DONE;
            cnt_d   = '0;
            if (state_q == IF_RD) begin
              if_done_d = 1'b1;
              if_inst_d = buf_d;
            end else begin
              mem_done_d = 1'b1;
              case (len_q)
                3'd1:    mem_rdata_d = {{24{sgn_q & buf_d[7]}}, buf_d[7:0]};
                3'd2:    mem_rdata_d = {{16{sgn_q & buf_d[15]}}, buf_d[15:0]};
                default: mem_rdata_d = buf_d;
              endcase
            end
          end
        end
      end

      MEM_WR: begin
        cnt_d = cnt_q + 3'd1;
        if (cnt_q < len_q) begin
          ram_a_d    = byte_addr;
          ram_dout_d = wr_byte;
        end else begin
          ram_wr_d   = 1'b0;
          state_d    = DONE;
          cnt_d      = '0;
          mem_done_d = 1'b1;
        end
      end

      DONE: begin
        state_d = IDLE;
        cnt_d   = '0;
      end

      default: begin
        state_d  = IDLE;
        cnt_d    = '0;
        ram_wr_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      len_q       <= '0;
      base_q      <= '0;
      wdata_q     <= '0;
      buf_q       <= '0;
      sgn_q       <= 1'b0;
      ram_a_q     <= '0;
      ram_dout_q  <= '0;
      ram_wr_q    <= 1'b0;
      if_done_q   <= 1'b0;
      mem_done_q  <= 1'b0;
      if_inst_q   <= '0;
      mem_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      base_q      <= base_d;
      wdata_q     <= wdata_d;
      buf_q       <= buf_d;
      sgn_q       <= sgn_d;
      ram_a_q     <= ram_a_d;
      ram_dout_q  <= ram_dout_d;
      ram_wr_q    <= ram_wr_d;
      if_done_q   <= if_done_d;
      mem_done_q  <= mem_done_d;
      if_inst_q   <= if_inst_d;
      mem_rdata_q <= mem_rdata_d;
    end
  end

  assign ram_a     = ram_a_q;
  assign ram_dout  = ram_dout_q;
  assign ram_wr    = ram_wr_q;
  assign if_done   = if_done_q;
  assign mem_done  = mem_done_q;
  assign if_inst   = if_inst_q;
  assign mem_rdata = mem_rdata_q;
  assign stall_if  = if_req & ~if_done_q;
  assign stall_mem = mem_req & ~mem_done_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: byte-wide synchronous RAM model, vector table for
// load/store transactions, scoreboard of expected read data, and hand-written corner sequences.
module tb_mem_arbiter;
  localparam int AW = 17;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req, if_cancel, if_done;
  logic [31:0]   if_addr, if_inst;
  logic          mem_req, mem_we, mem_signed, mem_done;
  logic [1:0]    mem_size;
  logic [31:0]   mem_addr, mem_wdata, mem_rdata;
  logic [AW-1:0] ram_a;
  logic [7:0]    ram_dout, ram_din;
  logic          ram_wr, stall_if, stall_mem;

  always #5 clk = ~clk;

  mem_arbiter #(.MEM_ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_cancel(if_cancel),
    .if_done(if_done), .if_inst(if_inst),
    .mem_req(mem_req), .mem_we(mem_we), .mem_size(mem_size), .mem_signed(mem_signed),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_done(mem_done), .mem_rdata(mem_rdata),
    .ram_a(ram_a), .ram_dout(ram_dout), .ram_wr(ram_wr), .ram_din(ram_din),
    .stall_if(stall_if), .stall_mem(stall_mem)
  );

  logic [7:0] ram [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (ram_wr) ram[ram_a] <= ram_dout;
    ram_din <= ram[ram_a];
  end

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          is_if;
    logic [31:0] data;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          lat;
  } vec_t;
  vec_t vecs [14];

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic sb_check(input bit is_if, input logic [31:0] act, input string name);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s: done with empty scoreboard, got %h", name, act);
    end else begin
      e = sb.pop_front();
      if (e.is_if != is_if || act !== e.data) begin
        errors++;
        $display("FAIL %s: got port_if=%0d data %h expected port_if=%0d data %h",
                 name, is_if, act, e.is_if, e.data);
      end
    end
  endtask

  task automatic run_mem(input vec_t v, input string name);
    int cyc, wr_cyc, stall_bad, n;
    bit got;
    n = (v.size == 2'd0) ? 1 : (v.size == 2'd1) ? 2 : 4;
    mem_req = 1'b1; mem_we = v.we; mem_size = v.size; mem_signed = v.sgn;
    mem_addr = v.addr; mem_wdata = v.wdata;
    if (!v.we) sb.push_back('{1'b0, v.rdata});
    cyc = 0; wr_cyc = 0; stall_bad = 0; got = 1'b0;
    while (!got && cyc < 20) begin
      step;
      cyc++;
      if (ram_wr) wr_cyc++;
      if (mem_done) got = 1'b1;
      else if (stall_mem !== 1'b1) stall_bad++;
    end
    chk({name, " latency"}, cyc, v.lat);
    chk({name, " ram_wr cycles"}, wr_cyc, v.we ? n : 0);
    chk({name, " stall_mem while busy"}, stall_bad, 0);
    if (got) begin
      chk({name, " stall_mem at done"}, stall_mem, 1'b0);
      if (!v.we) sb_check(1'b0, mem_rdata, name);
    end
    step;
    mem_req = 1'b0;
    chk({name, " done is one cycle"}, mem_done, 1'b0);
  endtask

  int cyc, bad;
  bit got;

  initial begin
    for (int i = 0; i < (1<<AW); i++) ram[i] <= '0;
    ram[32'h100] <= 8'h13; ram[32'h101] <= 8'h05;
    ram[32'h20]  <= 8'h80;
    ram[32'h40]  <= 8'h11; ram[32'h41] <= 8'h22; ram[32'h42] <= 8'h33; ram[32'h43] <= 8'h44;
    ram[32'h51]  <= 8'hFE; ram[32'h52] <= 8'h81;

    //          we    size  sgn   addr           wdata          rdata          lat
    vecs[0]  = '{1'b0, 2'd0, 1'b1, 32'h0000_0020, 32'hDEAD_BEEF, 32'hFFFF_FF80, 3};
    vecs[1]  = '{1'b0, 2'd0, 1'b0, 32'h0000_0020, 32'hDEAD_BEEF, 32'h0000_0080, 3};
    vecs[2]  = '{1'b0, 2'd2, 1'b0, 32'h0000_0040, 32'hDEAD_BEEF, 32'h4433_2211, 6};
    vecs[3]  = '{1'b0, 2'd1, 1'b1, 32'h0000_0051, 32'hDEAD_BEEF, 32'hFFFF_81FE, 4};
    vecs[4]  = '{1'b0, 2'd1, 1'b0, 32'h0000_0051, 32'hDEAD_BEEF, 32'h0000_81FE, 4};
    vecs[5]  = '{1'b1, 2'd1, 1'b0, 32'h0001_FFFF, 32'h1234_BEEF, 32'h0,          3};
    vecs[6]  = '{1'b0, 2'd1, 1'b0, 32'h0001_FFFF, 32'hDEAD_BEEF, 32'h0000_BEEF, 4};
    vecs[7]  = '{1'b1, 2'd3, 1'b0, 32'h0000_0200, 32'hCAFE_F00D, 32'h0,          5};
    vecs[8]  = '{1'b0, 2'd2, 1'b0, 32'h0000_0200, 32'hDEAD_BEEF, 32'hCAFE_F00D, 6};
    vecs[9]  = '{1'b1, 2'd0, 1'b0, 32'h0000_0300, 32'h1234_565A, 32'h0,          2};
    vecs[10] = '{1'b0, 2'd2, 1'b0, 32'h0000_0300, 32'hDEAD_BEEF, 32'h0000_005A, 6};
    vecs[11] = '{1'b0, 2'd2, 1'b0, 32'hFFF4_0040, 32'hDEAD_BEEF, 32'h4433_2211, 6};
    vecs[12] = '{1'b0, 2'd0, 1'b1, 32'h0000_0040, 32'hDEAD_BEEF, 32'h0000_0011, 3};
    vecs[13] = '{1'b0, 2'd3, 1'b1, 32'h0000_0040, 32'hDEAD_BEEF, 32'h4433_2211, 6};

    rst = 1'b1; if_req = 1'b1; mem_req = 1'b1; if_cancel = 1'b0;
    if_addr = 32'h100; mem_we = 1'b1; mem_size = 2'd2; mem_signed = 1'b0;
    mem_addr = 32'h40; mem_wdata = 32'hFFFF_FFFF;

    // Reset with both requests asserted.
    for (int i = 0; i < 2; i++) begin
      step;
      chk("reset ram_a", ram_a, '0);
      chk("reset ram_dout", ram_dout, '0);
      chk("reset ram_wr", ram_wr, 1'b0);
      chk("reset dones", {if_done, mem_done}, 2'b00);
      chk("reset if_inst", if_inst, '0);
      chk("reset mem_rdata", mem_rdata, '0);
      chk("reset stalls", {stall_if, stall_mem}, 2'b11);
    end
    if_req = 1'b0; mem_req = 1'b0; rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step;
      chk("idle after reset", {ram_wr, if_done, mem_done, stall_if, stall_mem}, 5'b0);
    end
    chk("no write during reset", ram[32'h40], 8'h11);

    // Basic instruction fetch.
    if_req = 1'b1; if_addr = 32'h100;
    sb.push_back('{1'b1, 32'h0000_0513});
    cyc = 0; got = 1'b0;
    while (!got && cyc < 20) begin step; cyc++; if (if_done) got = 1'b1; end
    chk("fetch latency", cyc, 6);
    if (got) sb_check(1'b1, if_inst, "fetch 0x100");
    step; if_req = 1'b0;
    chk("fetch done one cycle", if_done, 1'b0);

    for (int i = 0; i < 14; i++) run_mem(vecs[i], $sformatf("vec%0d", i));

    chk("sh low byte at top", ram[32'h1FFFF], 8'hEF);
    chk("sh high byte wraps to 0", ram[0], 8'hBE);
    chk("sb writes one byte", ram[32'h301], 8'h00);
    chk("if_inst holds across loads", if_inst, 32'h0000_0513);

    // Simultaneous requests: MEM first, IF after.
    mem_req = 1'b1; mem_we = 1'b0; mem_size = 2'd2; mem_signed = 1'b0; mem_addr = 32'h40;
    if_req = 1'b1; if_addr = 32'h100;
    sb.push_back('{1'b0, 32'h4433_2211});
    sb.push_back('{1'b1, 32'h0000_0513});
    cyc = 0; bad = 0; got = 1'b0;
    while (!got && cyc < 20) begin
      step; cyc++;
      if (mem_done) got = 1'b1;
      if (if_done || stall_if !== 1'b1) bad++;
    end
    chk("both: mem latency", cyc, 6);
    if (got) sb_check(1'b0, mem_rdata, "both: mem data");
    step; mem_req = 1'b0;
    if (stall_if !== 1'b1) bad++;
    cyc = 0; got = 1'b0;
    while (!got && cyc < 20) begin
      step; cyc++;
      if (if_done) got = 1'b1;
      else if (stall_if !== 1'b1) bad++;
    end
    chk("both: if latency after mem", cyc, 6);
    chk("both: stall_if held", bad, 0);
    if (got) sb_check(1'b1, if_inst, "both: fetch data");
    chk("mem_rdata holds across fetch", mem_rdata, 32'h4433_2211);
    step; if_req = 1'b0;

    // Cancel at E2, redirected fetch accepted at E3.
    if_req = 1'b1; if_addr = 32'h40;
    step;
    step;
    if_cancel = 1'b1; if_addr = 32'h100;
    step;
    if_cancel = 1'b0;
    chk("cancel: no done at cancel edge", if_done, 1'b0);
    sb.push_back('{1'b1, 32'h0000_0513});
    cyc = 0; got = 1'b0;
    while (!got && cyc < 20) begin step; cyc++; if (if_done) got = 1'b1; end
    chk("cancel: refetch latency", cyc, 6);
    if (got) sb_check(1'b1, if_inst, "cancel: refetch data");
    step; if_req = 1'b0;

    // Cancel and mem_req at the same IF_RD edge.
    if_req = 1'b1; if_addr = 32'h40;
    step;
    if_cancel = 1'b1; if_req = 1'b0;
    mem_req = 1'b1; mem_we = 1'b0; mem_size = 2'd2; mem_addr = 32'h200;
    step;
    if_cancel = 1'b0;
    sb.push_back('{1'b0, 32'hCAFE_F00D});
    cyc = 0; bad = 0; got = 1'b0;
    while (!got && cyc < 20) begin
      step; cyc++;
      if (if_done) bad++;
      if (mem_done) got = 1'b1;
    end
    chk("cancel+mem: mem latency", cyc, 6);
    chk("cancel+mem: no if_done", bad, 0);
    if (got) sb_check(1'b0, mem_rdata, "cancel+mem: data");
    step; mem_req = 1'b0;

    // Reset in the middle of a word store.
    mem_req = 1'b1; mem_we = 1'b1; mem_size = 2'd2; mem_addr = 32'h400; mem_wdata = 32'hA1B2_C3D4;
    step;
    step;
    rst = 1'b1;
    step;
    chk("midreset ram_wr", ram_wr, 1'b0);
    chk("midreset mem_rdata cleared", mem_rdata, '0);
    chk("midreset if_inst cleared", if_inst, '0);
    mem_req = 1'b0; rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      step;
      if (mem_done || ram_wr) bad++;
    end
    chk("midreset no done/write after", bad, 0);
    chk("midreset byte0 written", ram[32'h400], 8'hD4);
    chk("midreset byte1 written", ram[32'h401], 8'hC3);
    chk("midreset byte2 untouched", ram[32'h402], 8'h00);
    chk("midreset byte3 untouched", ram[32'h403], 8'h00);
    chk("scoreboard drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
